// File: rtl/tcp_framer.sv
// TCP segment builder: emits a fixed 20-byte header (checksum zero), then passes the payload through.
// Optional build macro TCP_FRAMER_HEADER_ONLY_EN: zero-length segments end at HDR4 with tlast and consume no payload.
module tcp_framer (
    input  logic        clk,
    input  logic        areset,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [15:0] hdr_length_bytes,
    input  logic [15:0] hdr_src_port,
    input  logic [15:0] hdr_dst_port,
    input  logic [31:0] hdr_seq_num,
    input  logic [31:0] hdr_ack_num,
    input  logic        hdr_ack,
    input  logic        hdr_rst,
    input  logic        hdr_syn,
    input  logic        hdr_fin,
    input  logic [15:0] hdr_window_size,
    input  logic        axis_i_tvalid,
    output logic        axis_i_tready,
    input  logic        axis_i_tlast,
    input  logic [31:0] axis_i_tdata,
    input  logic [3:0]  axis_i_tkeep,
    output logic        axis_o_tvalid,
    input  logic        axis_o_tready,
    output logic        axis_o_tlast,
    output logic [31:0] axis_o_tdata,
    output logic [3:0]  axis_o_tkeep,
    output logic [15:0] axis_o_length_bytes
);

    localparam int AXIS_BYTES = 4;
    localparam logic [15:0] HDR_BYTES = 16'd20;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR0    = 3'd1,
        S_HDR1    = 3'd2,
        S_HDR2    = 3'd3,
        S_HDR3    = 3'd4,
        S_HDR4    = 3'd5,
        S_PAYLOAD = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;
    logic [31:0] r_seq_num;
    logic [31:0] r_ack_num;
    logic        r_flag_ack;
    logic        r_flag_rst;
    logic        r_flag_syn;
    logic        r_flag_fin;
    logic [15:0] r_window_size;
    logic [15:0] r_seg_length;
`ifdef TCP_FRAMER_HEADER_ONLY_EN
    logic [15:0] r_length_bytes;
`endif

    logic [15:0] w_src_net;
    logic [15:0] w_dst_net;
    logic [15:0] w_win_net;
    logic [31:0] w_seq_net;
    logic [31:0] w_ack_net;
    logic [7:0]  w_flags;
    logic        w_hdr_handshake;
    logic        w_last_hdr;

    // Network order: the most significant byte lands on byte lane 0 (sent first).
    genvar gi;
    generate
        for (gi = 0; gi < AXIS_BYTES; gi++) begin : g_swap32
            assign w_seq_net[8*gi +: 8] = r_seq_num[8*(AXIS_BYTES-1-gi) +: 8];
            assign w_ack_net[8*gi +: 8] = r_ack_num[8*(AXIS_BYTES-1-gi) +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_swap16
            assign w_src_net[8*gi +: 8] = r_src_port[8*(1-gi) +: 8];
            assign w_dst_net[8*gi +: 8] = r_dst_port[8*(1-gi) +: 8];
            assign w_win_net[8*gi +: 8] = r_window_size[8*(1-gi) +: 8];
        end
    endgenerate

    assign w_flags             = {3'b000, r_flag_ack, 1'b0, r_flag_rst, r_flag_syn, r_flag_fin};
    assign w_hdr_handshake     = (r_state == S_IDLE) && hdr_valid;
    assign axis_o_length_bytes = r_seg_length;

`ifdef TCP_FRAMER_HEADER_ONLY_EN
    assign w_last_hdr = (r_length_bytes == 16'd0);
`else
    assign w_last_hdr = 1'b0;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_src_port    <= '0;
            r_dst_port    <= '0;
            r_seq_num     <= '0;
            r_ack_num     <= '0;
            r_flag_ack    <= 1'b0;
            r_flag_rst    <= 1'b0;
            r_flag_syn    <= 1'b0;
            r_flag_fin    <= 1'b0;
            r_window_size <= '0;
            r_seg_length  <= '0;
`ifdef TCP_FRAMER_HEADER_ONLY_EN
            r_length_bytes <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_hdr_handshake) begin
                r_src_port    <= hdr_src_port;
                r_dst_port    <= hdr_dst_port;
                r_seq_num     <= hdr_seq_num;
                r_ack_num     <= hdr_ack_num;
                r_flag_ack    <= hdr_ack;
                r_flag_rst    <= hdr_rst;
                r_flag_syn    <= hdr_syn;
                r_flag_fin    <= hdr_fin;
                r_window_size <= hdr_window_size;
                r_seg_length  <= hdr_length_bytes + HDR_BYTES;
`ifdef TCP_FRAMER_HEADER_ONLY_EN
                r_length_bytes <= hdr_length_bytes;
`endif
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        hdr_ready     = 1'b0;
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = '0;
        axis_o_tkeep  = '0;
        case (r_state)
            S_IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) begin
                    w_state_next = S_HDR0;
                end
            end
            S_HDR0: begin
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tdata  = {w_dst_net, w_src_net};
                if (axis_o_tready) begin
                    w_state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tdata  = w_seq_net;
                if (axis_o_tready) begin
                    w_state_next = S_HDR2;
                end
            end
            S_HDR2: begin
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tdata  = w_ack_net;
                if (axis_o_tready) begin
                    w_state_next = S_HDR3;
                end
            end
            S_HDR3: begin
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tdata  = {w_win_net, w_flags, 8'h50};
                if (axis_o_tready) begin
                    w_state_next = S_HDR4;
                end
            end
            S_HDR4: begin
                // Checksum and urgent pointer are both zero on this beat.
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tlast  = w_last_hdr;
                if (axis_o_tready) begin
                    w_state_next = w_last_hdr ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                axis_o_tvalid = axis_i_tvalid;
                axis_i_tready = axis_o_tready;
                axis_o_tdata  = axis_i_tdata;
                axis_o_tkeep  = axis_i_tkeep;
                axis_o_tlast  = axis_i_tlast;
                if (axis_i_tvalid && axis_o_tready && axis_i_tlast) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tcp_framer.sv
// Self-checking bench for tcp_framer: random segments and backpressure checked against a byte-level TCP header model.
// Build with +define+TCP_FRAMER_HEADER_ONLY_EN to also exercise zero-length segments.
module tb_tcp_framer;

    logic        clk = 1'b0;
    logic        areset;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [15:0] hdr_length_bytes;
    logic [15:0] hdr_src_port;
    logic [15:0] hdr_dst_port;
    logic [31:0] hdr_seq_num;
    logic [31:0] hdr_ack_num;
    logic        hdr_ack, hdr_rst, hdr_syn, hdr_fin;
    logic [15:0] hdr_window_size;
    logic        axis_i_tvalid;
    logic        axis_i_tready;
    logic        axis_i_tlast;
    logic [31:0] axis_i_tdata;
    logic [3:0]  axis_i_tkeep;
    logic        axis_o_tvalid;
    logic        axis_o_tready;
    logic        axis_o_tlast;
    logic [31:0] axis_o_tdata;
    logic [3:0]  axis_o_tkeep;
    logic [15:0] axis_o_length_bytes;

    tcp_framer dut (
        .clk                 (clk),
        .areset              (areset),
        .hdr_valid           (hdr_valid),
        .hdr_ready           (hdr_ready),
        .hdr_length_bytes    (hdr_length_bytes),
        .hdr_src_port        (hdr_src_port),
        .hdr_dst_port        (hdr_dst_port),
        .hdr_seq_num         (hdr_seq_num),
        .hdr_ack_num         (hdr_ack_num),
        .hdr_ack             (hdr_ack),
        .hdr_rst             (hdr_rst),
        .hdr_syn             (hdr_syn),
        .hdr_fin             (hdr_fin),
        .hdr_window_size     (hdr_window_size),
        .axis_i_tvalid       (axis_i_tvalid),
        .axis_i_tready       (axis_i_tready),
        .axis_i_tlast        (axis_i_tlast),
        .axis_i_tdata        (axis_i_tdata),
        .axis_i_tkeep        (axis_i_tkeep),
        .axis_o_tvalid       (axis_o_tvalid),
        .axis_o_tready       (axis_o_tready),
        .axis_o_tlast        (axis_o_tlast),
        .axis_o_tdata        (axis_o_tdata),
        .axis_o_tkeep        (axis_o_tkeep),
        .axis_o_length_bytes (axis_o_length_bytes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0]  len;
        logic [15:0]  src;
        logic [15:0]  dst;
        logic [31:0]  seq;
        logic [31:0]  ackn;
        logic         fa, fr, fs, ff;
        logic [15:0]  win;
        int           nbeats;
        logic [255:0] data;
        logic [3:0]   lastkeep;
    } seg_t;

    seg_t        seg_q[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];
    logic [15:0] exp_len[$];
    logic [31:0] out_data[$];
    logic [3:0]  out_keep[$];
    logic        out_last[$];
    logic [15:0] out_len[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    int          stall_bad;
    int          tlast_hr_bad;
    int          in_rdy_cnt;
    logic        timed_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: lay out the 20 header bytes in wire order, then pack 4 bytes per beat, byte 0 on the low lane.
    task automatic model_push(input seg_t s);
        logic [7:0] b [20];
        logic       hdr_only;
        b[0]  = s.src[15:8];  b[1]  = s.src[7:0];
        b[2]  = s.dst[15:8];  b[3]  = s.dst[7:0];
        for (int k = 0; k < 4; k++) begin
            b[4+k] = s.seq[31-8*k -: 8];
            b[8+k] = s.ackn[31-8*k -: 8];
        end
        b[12] = 8'h50;
        b[13] = {3'b000, s.fa, 1'b0, s.fr, s.fs, s.ff};
        b[14] = s.win[15:8];  b[15] = s.win[7:0];
        for (int k = 16; k < 20; k++) b[k] = 8'h00;
`ifdef TCP_FRAMER_HEADER_ONLY_EN
        hdr_only = (s.len == 16'd0);
`else
        hdr_only = 1'b0;
`endif
        for (int j = 0; j < 5; j++) begin
            exp_data.push_back({b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]});
            exp_keep.push_back(4'hF);
            exp_last.push_back(hdr_only && (j == 4));
            exp_len.push_back(s.len + 16'd20);
        end
        if (!hdr_only) begin
            for (int j = 0; j < s.nbeats; j++) begin
                exp_data.push_back(s.data[32*j +: 32]);
                exp_keep.push_back((j == s.nbeats - 1) ? s.lastkeep : 4'hF);
                exp_last.push_back(j == s.nbeats - 1);
                exp_len.push_back(s.len + 16'd20);
            end
        end
    endtask

    task automatic make_seg(input int nbytes, output seg_t s);
        int rem;
        s.len    = 16'(nbytes);
        s.src    = 16'($urandom);
        s.dst    = 16'($urandom);
        s.seq    = $urandom;
        s.ackn   = $urandom;
        s.fa     = 1'($urandom_range(0, 1));
        s.fr     = 1'($urandom_range(0, 1));
        s.fs     = 1'($urandom_range(0, 1));
        s.ff     = 1'($urandom_range(0, 1));
        s.win    = 16'($urandom);
        s.nbeats = (nbytes + 3) / 4;
        rem      = nbytes % 4;
        s.lastkeep = (rem == 0) ? 4'hF : 4'((1 << rem) - 1);
        for (int k = 0; k < 8; k++) s.data[32*k +: 32] = $urandom;
    endtask

    task automatic clear_exp();
        exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_len.delete();
    endtask

    // Drives every segment in seg_q (hdr_valid held while segments remain) and records output beats.
    task automatic run_segs(input int rdy_mode);
        int   hi = 0, pi = 0, pb = 0, nl = 0, budget = 0;
        logic stalled = 1'b0;
        logic [36:0] snap = '0;
        out_data.delete(); out_keep.delete(); out_last.delete(); out_len.delete();
        out_cyc.delete(); acc_cyc.delete();
        stall_bad = 0; tlast_hr_bad = 0; in_rdy_cnt = 0;
        @(posedge clk); #1;
        while (nl < seg_q.size() && budget < 600) begin
            if (hi < seg_q.size()) begin
                hdr_valid        = 1'b1;
                hdr_length_bytes = seg_q[hi].len;
                hdr_src_port     = seg_q[hi].src;
                hdr_dst_port     = seg_q[hi].dst;
                hdr_seq_num      = seg_q[hi].seq;
                hdr_ack_num      = seg_q[hi].ackn;
                hdr_ack          = seg_q[hi].fa;
                hdr_rst          = seg_q[hi].fr;
                hdr_syn          = seg_q[hi].fs;
                hdr_fin          = seg_q[hi].ff;
                hdr_window_size  = seg_q[hi].win;
            end else begin
                hdr_valid        = 1'b0;
                hdr_src_port     = 16'($urandom);
                hdr_seq_num      = $urandom;
            end
            while (pi < seg_q.size() && pb >= seg_q[pi].nbeats) begin
                pi++;
                pb = 0;
            end
            if (pi < seg_q.size()) begin
                axis_i_tvalid = 1'b1;
                axis_i_tdata  = seg_q[pi].data[32*pb +: 32];
                axis_i_tlast  = (pb == seg_q[pi].nbeats - 1);
                axis_i_tkeep  = axis_i_tlast ? seg_q[pi].lastkeep : 4'hF;
            end else begin
                axis_i_tvalid = 1'b0;
                axis_i_tdata  = $urandom;
                axis_i_tlast  = 1'b0;
                axis_i_tkeep  = 4'h0;
            end
            axis_o_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled && (!axis_o_tvalid || {axis_o_tdata, axis_o_tkeep, axis_o_tlast} !== snap))
                stall_bad++;
            stalled = axis_o_tvalid && !axis_o_tready;
            snap    = {axis_o_tdata, axis_o_tkeep, axis_o_tlast};
            if (hdr_valid && hdr_ready) begin
                acc_cyc.push_back(cyc);
                hi++;
            end
            if (axis_i_tvalid && axis_i_tready) pb++;
            if (axis_i_tready) in_rdy_cnt++;
            if (axis_o_tvalid && axis_o_tready) begin
                $display("beat cyc=%0d data=%08h keep=%h last=%b len=%0d",
                         cyc, axis_o_tdata, axis_o_tkeep, axis_o_tlast, axis_o_length_bytes);
                out_data.push_back(axis_o_tdata);
                out_keep.push_back(axis_o_tkeep);
                out_last.push_back(axis_o_tlast);
                out_len.push_back(axis_o_length_bytes);
                out_cyc.push_back(cyc);
                if (axis_o_tlast) begin
                    nl++;
                    if (hdr_ready) tlast_hr_bad++;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        timed_out     = (nl < seg_q.size());
        hdr_valid     = 1'b0;
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        axis_o_tready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tkeep} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b l=%b d=%08h k=%h, want all 0",
                     axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tkeep);
        end
        n_cmp++;
        if (axis_o_length_bytes !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_len: got %0d want 0", axis_o_length_bytes);
        end
        n_cmp++;
        if (hdr_ready !== 1'b1 || axis_i_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got hdr_ready=%b in_ready=%b want 1/0", hdr_ready, axis_i_tready);
        end
        @(posedge clk); #1;
        areset = 1'b0;
        $display("reset released at cyc=%0d", cyc);
    endtask

    task automatic test_basic();
        seg_t s;
        make_seg(8, s);
        s.src = 16'h1234; s.dst = 16'h0050; s.seq = 32'h01020304; s.ackn = 32'hA0B0C0D0;
        s.fa = 1'b1; s.fr = 1'b0; s.fs = 1'b0; s.ff = 1'b0; s.win = 16'hFFFF;
        seg_q.delete(); seg_q.push_back(s);
        clear_exp(); model_push(s);
        run_segs(0);
        n_cmp++;
        if (timed_out || out_data.size() != 7) begin
            n_bad++;
            $display("FAIL basic_count: got %0d beats (timeout=%b) want 7", out_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i], out_len[i]} !== {exp_data[i], exp_keep[i], exp_last[i], exp_len[i]}) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got %08h/%h/%b/%0d want %08h/%h/%b/%0d", i,
                         out_data[i], out_keep[i], out_last[i], out_len[i],
                         exp_data[i], exp_keep[i], exp_last[i], exp_len[i]);
            end
        end
        if (out_data.size() >= 7 && acc_cyc.size() >= 1) begin
            n_cmp++;
            if (out_data[0] !== 32'h50003412 || out_data[1] !== 32'h04030201 || out_data[3] !== 32'hFFFF1050) begin
                n_bad++;
                $display("FAIL basic_const: got %08h %08h %08h want 50003412 04030201 FFFF1050",
                         out_data[0], out_data[1], out_data[3]);
            end
            n_cmp++;
            if (out_len[0] !== 16'd28) begin
                n_bad++;
                $display("FAIL basic_len: got %0d want 28", out_len[0]);
            end
            n_cmp++;
            if (out_cyc[0] - acc_cyc[0] != 1 || out_cyc[5] - acc_cyc[0] != 6) begin
                n_bad++;
                $display("FAIL basic_latency: got hdr0 +%0d payload +%0d want +1 +6",
                         out_cyc[0] - acc_cyc[0], out_cyc[5] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 4; it++) begin
            seg_t s;
            make_seg((it == 0) ? 8 : $urandom_range(1, 32), s);
            seg_q.delete(); seg_q.push_back(s);
            clear_exp(); model_push(s);
            run_segs(1);
            n_cmp++;
            if (timed_out || out_data.size() != exp_data.size()) begin
                n_bad++;
                $display("FAIL bp_count%0d: got %0d beats (timeout=%b) want %0d",
                         it, out_data.size(), timed_out, exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
                n_cmp++;
                if ({out_data[i], out_keep[i], out_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                    n_bad++;
                    $display("FAIL bp%0d_beat%0d: got %08h/%h/%b want %08h/%h/%b", it, i,
                             out_data[i], out_keep[i], out_last[i], exp_data[i], exp_keep[i], exp_last[i]);
                end
            end
            n_cmp++;
            if (stall_bad != 0) begin
                n_bad++;
                $display("FAIL bp_stable%0d: got %0d unstable stall cycles want 0", it, stall_bad);
            end
        end
    endtask

    task automatic test_partial();
        seg_t s;
        make_seg(5, s);
        seg_q.delete(); seg_q.push_back(s);
        clear_exp(); model_push(s);
        run_segs(0);
        n_cmp++;
        if (timed_out || out_data.size() != 7) begin
            n_bad++;
            $display("FAIL partial_count: got %0d beats (timeout=%b) want 7", out_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                n_bad++;
                $display("FAIL partial_beat%0d: got %08h/%h/%b want %08h/%h/%b", i,
                         out_data[i], out_keep[i], out_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        if (out_data.size() == 7) begin
            n_cmp++;
            if (out_keep[6] !== 4'b0001 || out_len[6] !== 16'd25) begin
                n_bad++;
                $display("FAIL partial_keep_len: got keep=%h len=%0d want 1 25", out_keep[6], out_len[6]);
            end
        end
    endtask

    task automatic test_back_to_back();
        seg_t s0, s1;
        int   i2;
        make_seg($urandom_range(1, 16), s0);
        make_seg($urandom_range(1, 16), s1);
        seg_q.delete(); seg_q.push_back(s0); seg_q.push_back(s1);
        clear_exp(); model_push(s0); model_push(s1);
        run_segs(0);
        n_cmp++;
        if (timed_out || out_data.size() != exp_data.size()) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d beats (timeout=%b) want %0d", out_data.size(), timed_out, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i], out_len[i]} !== {exp_data[i], exp_keep[i], exp_last[i], exp_len[i]}) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got %08h/%h/%b/%0d want %08h/%h/%b/%0d", i,
                         out_data[i], out_keep[i], out_last[i], out_len[i],
                         exp_data[i], exp_keep[i], exp_last[i], exp_len[i]);
            end
        end
        i2 = 5 + s0.nbeats;
        if (out_cyc.size() > i2) begin
            n_cmp++;
            if (out_cyc[i2] - out_cyc[i2-1] != 2) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0d cycles from tlast to HDR0 want 2", out_cyc[i2] - out_cyc[i2-1]);
            end
        end
        n_cmp++;
        if (tlast_hr_bad != 0) begin
            n_bad++;
            $display("FAIL b2b_ready_tlast: got %0d overlaps want 0", tlast_hr_bad);
        end
    endtask

    task automatic test_random_stream();
        seg_q.delete(); clear_exp();
        for (int k = 0; k < 5; k++) begin
            seg_t s;
            make_seg($urandom_range(1, 32), s);
            if (k == 2) s.len = 16'hFFF0;
            seg_q.push_back(s);
            model_push(s);
        end
        run_segs(1);
        n_cmp++;
        if (timed_out || out_data.size() != exp_data.size()) begin
            n_bad++;
            $display("FAIL rand_count: got %0d beats (timeout=%b) want %0d", out_data.size(), timed_out, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i], out_len[i]} !== {exp_data[i], exp_keep[i], exp_last[i], exp_len[i]}) begin
                n_bad++;
                $display("FAIL rand_beat%0d: got %08h/%h/%b/%0d want %08h/%h/%b/%0d", i,
                         out_data[i], out_keep[i], out_last[i], out_len[i],
                         exp_data[i], exp_keep[i], exp_last[i], exp_len[i]);
            end
        end
        n_cmp++;
        if (stall_bad != 0 || tlast_hr_bad != 0) begin
            n_bad++;
            $display("FAIL rand_rules: got stall_bad=%0d tlast_hr=%0d want 0 0", stall_bad, tlast_hr_bad);
        end
    endtask

`ifdef TCP_FRAMER_HEADER_ONLY_EN
    task automatic test_header_only();
        seg_t s;
        make_seg(0, s);
        s.fa = 1'b0; s.fr = 1'b0; s.fs = 1'b1; s.ff = 1'b0;
        seg_q.delete(); seg_q.push_back(s);
        clear_exp(); model_push(s);
        run_segs(0);
        n_cmp++;
        if (timed_out || out_data.size() != 5) begin
            n_bad++;
            $display("FAIL hdronly_count: got %0d beats (timeout=%b) want 5", out_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
                n_bad++;
                $display("FAIL hdronly_beat%0d: got %08h/%h/%b want %08h/%h/%b", i,
                         out_data[i], out_keep[i], out_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        if (out_data.size() == 5) begin
            n_cmp++;
            if (out_data[3][15:8] !== 8'h02 || out_last[4] !== 1'b1) begin
                n_bad++;
                $display("FAIL hdronly_flags: got flags=%02h last=%b want 02 1", out_data[3][15:8], out_last[4]);
            end
        end
        n_cmp++;
        if (in_rdy_cnt != 0) begin
            n_bad++;
            $display("FAIL hdronly_in_ready: got %0d cycles high want 0", in_rdy_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid();
        seg_t s;
        make_seg(12, s);
        clear_exp(); model_push(s);
        @(posedge clk); #1;
        hdr_valid = 1'b1; hdr_length_bytes = s.len; hdr_src_port = s.src; hdr_dst_port = s.dst;
        hdr_seq_num = s.seq; hdr_ack_num = s.ackn; hdr_ack = s.fa; hdr_rst = s.fr;
        hdr_syn = s.fs; hdr_fin = s.ff; hdr_window_size = s.win;
        axis_o_tready = 1'b1; axis_i_tvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hdr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_accept: got hdr_ready=%b want 1", hdr_ready);
        end
        @(posedge clk); #1; hdr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== exp_data[2]) begin
            n_bad++;
            $display("FAIL rstmid_hdr2: got v=%b d=%08h want 1 %08h", axis_o_tvalid, axis_o_tdata, exp_data[2]);
        end
        areset = 1'b1;
        #1;
        n_cmp++;
        if (axis_o_tvalid !== 1'b0 || axis_o_length_bytes !== 16'd0 || hdr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_async: got v=%b len=%0d hdr_ready=%b want 0 0 1",
                     axis_o_tvalid, axis_o_length_bytes, hdr_ready);
        end
        @(posedge clk); #1;
        areset = 1'b0;
        axis_o_tready = 1'b0;
        $display("mid-segment reset applied at cyc=%0d", cyc);
        make_seg($urandom_range(1, 20), s);
        seg_q.delete(); seg_q.push_back(s);
        clear_exp(); model_push(s);
        run_segs(0);
        n_cmp++;
        if (timed_out || out_data.size() != exp_data.size()) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d beats (timeout=%b) want %0d", out_data.size(), timed_out, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < out_data.size(); i++) begin
            n_cmp++;
            if ({out_data[i], out_keep[i], out_last[i], out_len[i]} !== {exp_data[i], exp_keep[i], exp_last[i], exp_len[i]}) begin
                n_bad++;
                $display("FAIL rstmid_beat%0d: got %08h/%h/%b/%0d want %08h/%h/%b/%0d", i,
                         out_data[i], out_keep[i], out_last[i], out_len[i],
                         exp_data[i], exp_keep[i], exp_last[i], exp_len[i]);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        hdr_valid = 1'b0; hdr_length_bytes = '0; hdr_src_port = '0; hdr_dst_port = '0;
        hdr_seq_num = '0; hdr_ack_num = '0; hdr_ack = 1'b0; hdr_rst = 1'b0;
        hdr_syn = 1'b0; hdr_fin = 1'b0; hdr_window_size = '0;
        axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0; axis_i_tdata = '0; axis_i_tkeep = '0;
        axis_o_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_partial();
        test_back_to_back();
        test_random_stream();
`ifdef TCP_FRAMER_HEADER_ONLY_EN
        test_header_only();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcp_framer.md
# tcp_framer

Transmit-side TCP segment builder. Takes a 4-byte-wide payload stream plus per-segment header fields and emits a complete TCP segment: a fixed 20-byte header with no options, followed by the payload. It sits between the application/connection logic and the IP framer. It supplies the segment length the IP framer needs for its total-length field. The checksum field is transmitted as zero; the downstream checksum-insertion stage owns the checksum.

## Interface
Parameters:
- AXIS_BYTES, 4 (localparam, fixed): stream width in bytes. Byte 0 is on tdata[7:0] and is transmitted first.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - areset  in  1  asynchronous, active-high reset
- Header handshake and fields:
  - hdr_valid  in  1  header fields below are valid
  - hdr_ready  out  1  header accepted; high only in IDLE
  - hdr_length_bytes  in  16  payload length in bytes
  - hdr_src_port, hdr_dst_port  in  16 each  host order
  - hdr_seq_num, hdr_ack_num  in  32 each  host order
  - hdr_ack, hdr_rst, hdr_syn, hdr_fin  in  1 each  flags
  - hdr_window_size  in  16  host order
- Payload stream in:
  - axis_i_tvalid/tready/tlast  in/out/in  1  payload handshake
  - axis_i_tdata  in  32
  - axis_i_tkeep  in  4
- Segment stream out:
  - axis_o_tvalid/tready/tlast  out/in/out  1
  - axis_o_tdata  out  32
  - axis_o_tkeep  out  4
- axis_o_length_bytes  out  16  total segment length, equal to payload + 20; held for the whole segment

## Operation
- States: IDLE, HDR0, HDR1, HDR2, HDR3, HDR4, PAYLOAD.
- IDLE:
  - hdr_ready=1, axis_o_tvalid=0, axis_i_tready=0.
  - On hdr_valid, register all hdr_* fields, set axis_o_length_bytes = hdr_length_bytes + 20 (16-bit, wraps modulo 2^16), go to HDR0.
- HDR0..HDR4: axis_o_tvalid=1, tkeep=4'hF, tlast=0, axis_i_tready=0. Advance on axis_o_tready. All fields are sent in network order (MSB byte first), taken from registered fields:
  - HDR0: tdata[15:0] = swap(src_port), tdata[31:16] = swap(dst_port).
  - HDR1: swap4(seq_num).
  - HDR2: swap4(ack_num).
  - HDR3:
    - tdata[7:0] = 8'h50 (data offset 5, reserved 0).
    - tdata[15:8] = {3'b0, ack, 1'b0, rst, syn, fin}, i.e. ACK=bit12, RST=bit10, SYN=bit9, FIN=bit8; CWR/ECE/URG/PSH=0.
    - tdata[31:16] = swap(window_size).
  - HDR4: checksum=0, urgent pointer=0 (tdata=0). Next state is PAYLOAD; see Configuration for the zero-length case.
- PAYLOAD:
  - Combinational pass-through: axis_o_tvalid=axis_i_tvalid, axis_i_tready=axis_o_tready, tdata/tkeep/tlast copied from input.
  - On an accepted beat with tlast, return to IDLE.
- No check is made that hdr_length_bytes matches the actual payload byte count; upstream guarantees it.
- Payload beats presented outside PAYLOAD are stalled (tready=0) and never dropped.

## Timing
- Reset values: state=IDLE, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_o_tkeep=0, axis_o_length_bytes=0, all field registers 0. hdr_ready=1 immediately after reset.
- Latency: the first header beat is valid the cycle after the hdr handshake. Under continuous tready, HDR0..HDR4 occupy 5 consecutive cycles, and the first payload beat can transfer in the 6th.
- Throughput: back-to-back segments cost one IDLE cycle each. hdr_ready is never high in the same cycle as a payload tlast transfer.
- Header output holds tvalid and tdata stable while axis_o_tready=0 (AXIS rule).
- Registered fields and axis_o_length_bytes are not updated until the next IDLE handshake; hdr_* inputs may change freely after acceptance.
- areset mid-segment: output drops to the reset state asynchronously. The partial segment is truncated without tlast; downstream discards it.

## Configuration
- TCP_FRAMER_HEADER_ONLY_EN defined:
  - If the registered length is 0, HDR4 is emitted with tlast=1 and the FSM returns to IDLE.
  - No payload beat is consumed; used for pure SYN/ACK/FIN/RST segments.
- Undefined:
  - Length is used only for axis_o_length_bytes.
  - Every segment enters PAYLOAD and requires at least one payload beat. HDR4 tlast is always 0.

## Test plan
- Basic: src=0x1234, dst=0x0050, seq=0x01020304, ack=0xA0B0C0D0, ACK=1, window=0xFFFF, length=8, two full payload beats with tlast on the 2nd. Required: 7 output beats with HDR0=0x50003412, HDR1=0x04030201, HDR3=0xFFFF1050; axis_o_length_bytes=28.
- Backpressure: same stimulus with axis_o_tready toggling 1-0-0-1 randomly. Required: identical beat sequence, no duplicated or dropped beats, tdata stable while stalled.
- Partial last beat: length=5, last beat tkeep=4'b0001. Required: tkeep passed through unchanged; length out=25.
- Back-to-back: two segments with hdr_valid held high. Required: second HDR0 appears exactly 2 cycles after the first segment's tlast transfer; second segment's fields are correct.
- Header-only (macro defined): SYN=1, length=0, no payload. Required: 5 beats, HDR4 tlast=1, HDR3[15:8]=0x02, axis_i_tready never high.
- Reset during HDR2: assert areset. Required: axis_o_tvalid=0 the same cycle; after release, hdr_ready=1 and the next segment is framed correctly.
